// File: rtl/rect_fill_engine.sv
// rect_fill_engine: walks an axis-aligned rectangle in raster order and issues
// one framebuffer write per pixel, as a solid, transparent or opaque patterned fill.
// Build macro RECT_FILL_CLIP_EN: when defined, the rectangle is clipped to the
// framebuffer at command accept; when undefined, coordinates wrap at XW/YW bits.
module rect_fill_engine #(
  parameter int RESOLUTION_X   = 400,
  parameter int RESOLUTION_Y   = 300,
  parameter int PALETTE_LENGTH = 256,
  parameter int PATTERN_BITS   = 32,
  localparam int XW  = $clog2(RESOLUTION_X),
  localparam int YW  = $clog2(RESOLUTION_Y),
  localparam int IW  = $clog2(PALETTE_LENGTH),
  localparam int PCW = $clog2(RESOLUTION_X * RESOLUTION_Y + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [XW-1:0]           cmd_x0,
  input  logic [YW-1:0]           cmd_y0,
  input  logic [XW:0]             cmd_w,
  input  logic [YW:0]             cmd_h,
  input  logic [1:0]              cmd_mode,
  input  logic [IW-1:0]           cmd_index,
  input  logic [IW-1:0]           cmd_bg_index,
  input  logic [PATTERN_BITS-1:0] cmd_pattern,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [PCW-1:0]          pixel_count,
  output logic [XW-1:0]           fb_wr_x,
  output logic [YW-1:0]           fb_wr_y,
  output logic [IW-1:0]           fb_wr_index,
  output logic                    fb_wr_en,
  input  logic                    fb_wr_ready
);

  localparam int PBW = $clog2(PATTERN_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [XW-1:0]           x0_q, x0_d;
  logic [YW-1:0]           y0_q, y0_d;
  logic [XW:0]             w_q, w_d;
  logic [YW:0]             h_q, h_d;
  logic [1:0]              mode_q, mode_d;
  logic [IW-1:0]           fg_q, fg_d;
  logic [IW-1:0]           bg_q, bg_d;
  logic [PATTERN_BITS-1:0] pat_q, pat_d;
  logic [XW:0]             dx_q, dx_d;
  logic [YW:0]             dy_q, dy_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [PCW-1:0]          pix_cnt_q, pix_cnt_d;
  logic [XW-1:0]           wr_x_q, wr_x_d;
  logic [YW-1:0]           wr_y_q, wr_y_d;
  logic [IW-1:0]           wr_idx_q, wr_idx_d;
  logic                    wr_en_q, wr_en_d;

  logic [XW:0]             acc_w;
  logic [YW:0]             acc_h;
  logic                    acc_empty;
  logic                    last_pix;
  logic                    pix_done;
  logic [XW:0]             nxt_dx;
  logic [YW:0]             nxt_dy;
  logic                    nxt_p;

  // Pattern bit for a pixel, phased from the unclipped left edge
  function automatic logic pat_bit(input logic [PATTERN_BITS-1:0] pat,
                                   input logic [XW:0] dx);
    return pat[PBW'(dx)];
  endfunction

  // Whether a pixel is written at all (transparent mode skips p=0 pixels)
  function automatic logic pix_en(input logic [1:0] mode, input logic p);
    return (mode == 2'b01) ? p : 1'b1;
  endfunction

  // Palette index for a pixel (opaque mode uses the background on p=0)
  function automatic logic [IW-1:0] pix_idx(input logic [1:0] mode,
                                            input logic [IW-1:0] fg,
                                            input logic [IW-1:0] bg,
                                            input logic p);
    return (mode == 2'b10 && !p) ? bg : fg;
  endfunction

`ifdef RECT_FILL_CLIP_EN
  localparam logic [XW+1:0] RES_X_C = (XW+2)'(RESOLUTION_X);
  localparam logic [YW+1:0] RES_Y_C = (YW+2)'(RESOLUTION_Y);
  logic [XW+1:0] x_end;
  logic [YW+1:0] y_end;
`endif

  // Effective rectangle size of the command being offered, clipped if enabled
  always_comb begin
    acc_w     = cmd_w;
    acc_h     = cmd_h;
    acc_empty = (cmd_w == '0) || (cmd_h == '0);
`ifdef RECT_FILL_CLIP_EN
    x_end = (XW+2)'(cmd_x0) + (XW+2)'(cmd_w);
    y_end = (YW+2)'(cmd_y0) + (YW+2)'(cmd_h);
    if (((XW+2)'(cmd_x0) >= RES_X_C) || ((YW+2)'(cmd_y0) >= RES_Y_C)) begin
      acc_empty = 1'b1;
    end
    if (x_end > RES_X_C) begin
      acc_w = (XW+1)'(RES_X_C - (XW+2)'(cmd_x0));
    end
    if (y_end > RES_Y_C) begin
      acc_h = (YW+1)'(RES_Y_C - (YW+2)'(cmd_y0));
    end
`endif
  end

  // Next-state logic: accept, raster walk with backpressure, abort and done
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    mode_d   = mode_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    pat_d    = pat_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    pix_cnt_d = pix_cnt_q;
    wr_x_d   = wr_x_q;
    wr_y_d   = wr_y_q;
    wr_idx_d = wr_idx_q;
    wr_en_d  = wr_en_q;

    last_pix = (dx_q == w_q - 1'b1) && (dy_q == h_q - 1'b1);
    pix_done = !wr_en_q || fb_wr_ready;
    if (dx_q == w_q - 1'b1) begin
      nxt_dx = '0;
      nxt_dy = dy_q + 1'b1;
    end else begin
      nxt_dx = dx_q + 1'b1;
      nxt_dy = dy_q;
    end
    nxt_p = pat_bit(pat_q, nxt_dx);

    case (state_q)
      IDLE: begin
        wr_en_d = 1'b0;
        if (cmd_valid) begin
          x0_d      = cmd_x0;
          y0_d      = cmd_y0;
          w_d       = acc_w;
          h_d       = acc_h;
          mode_d    = cmd_mode;
          fg_d      = cmd_index;
          bg_d      = cmd_bg_index;
          pat_d     = cmd_pattern;
          dx_d      = '0;
          dy_d      = '0;
          pix_cnt_d = '0;
          if (acc_empty) begin
            state_d = DONE;
          end else begin
            state_d  = DRAW;
            wr_x_d   = cmd_x0;
            wr_y_d   = cmd_y0;
            wr_en_d  = pix_en(cmd_mode, cmd_pattern[0]);
            wr_idx_d = pix_idx(cmd_mode, cmd_index, cmd_bg_index, cmd_pattern[0]);
          end
        end
      end
      DRAW: begin
        if (wr_en_q && fb_wr_ready) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
        if (abort) begin
          state_d = IDLE;
          wr_en_d = 1'b0;
        end else if (pix_done) begin
          if (last_pix) begin
            state_d = DONE;
            wr_en_d = 1'b0;
          end else begin
            dx_d     = nxt_dx;
            dy_d     = nxt_dy;
            wr_x_d   = XW'((XW+1)'(x0_q) + nxt_dx);
            wr_y_d   = YW'((YW+1)'(y0_q) + nxt_dy);
            wr_en_d  = pix_en(mode_q, nxt_p);
            wr_idx_d = pix_idx(mode_q, fg_q, bg_q, nxt_p);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d == DRAW);
    done_d      = (state_d == DONE);
  end

  // State and registered outputs, cleared asynchronously by reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      mode_q      <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      pat_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_cnt_q   <= '0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_idx_q    <= '0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      mode_q      <= mode_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      pat_q       <= pat_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_cnt_q   <= pix_cnt_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_idx_q    <= wr_idx_d;
      wr_en_q     <= wr_en_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pixel_count = pix_cnt_q;
  assign fb_wr_x     = wr_x_q;
  assign fb_wr_y     = wr_y_q;
  assign fb_wr_index = wr_idx_q;
  assign fb_wr_en    = wr_en_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Testbench for rect_fill_engine: directed and random fill commands, checked
// every cycle against a pixel-list model of the rectangle fill.
`timescale 1ns/1ps
module tb_rect_fill_engine;

  localparam int RX  = 400;
  localparam int RY  = 300;
  localparam int PAL = 256;
  localparam int PB  = 32;
  localparam int XW  = $clog2(RX);
  localparam int YW  = $clog2(RY);
  localparam int IW  = $clog2(PAL);
  localparam int PCW = $clog2(RX * RY + 1);

  typedef struct {
    int x;
    int y;
    int idx;
    bit en;
  } pix_t;

  typedef enum int {M_IDLE, M_DRAW, M_DONE} mstate_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [XW-1:0] cmd_x0;
  logic [YW-1:0] cmd_y0;
  logic [XW:0]   cmd_w;
  logic [YW:0]   cmd_h;
  logic [1:0]    cmd_mode;
  logic [IW-1:0] cmd_index;
  logic [IW-1:0] cmd_bg_index;
  logic [PB-1:0] cmd_pattern;
  logic          abort;
  logic          busy;
  logic          done;
  logic [PCW-1:0] pixel_count;
  logic [XW-1:0] fb_wr_x;
  logic [YW-1:0] fb_wr_y;
  logic [IW-1:0] fb_wr_index;
  logic          fb_wr_en;
  logic          fb_wr_ready;

  logic rnd_bit      = 1'b1;
  logic ready_manual = 1'b1;
  logic rand_ready   = 1'b0;

  int      checks      = 0;
  int      failures    = 0;
  mstate_t mst         = M_IDLE;
  pix_t    exp_q[$];
  pix_t    build_q[$];
  int      mcnt        = 0;
  int      wr_seen     = 0;
  int      draw_cycles = 0;

  int sx[6] = '{10, 11, 12, 10, 11, 12};
  int sy[6] = '{20, 20, 20, 21, 21, 21};

  rect_fill_engine #(
    .RESOLUTION_X(RX),
    .RESOLUTION_Y(RY),
    .PALETTE_LENGTH(PAL),
    .PATTERN_BITS(PB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0),
    .cmd_y0(cmd_y0),
    .cmd_w(cmd_w),
    .cmd_h(cmd_h),
    .cmd_mode(cmd_mode),
    .cmd_index(cmd_index),
    .cmd_bg_index(cmd_bg_index),
    .cmd_pattern(cmd_pattern),
    .abort(abort),
    .busy(busy),
    .done(done),
    .pixel_count(pixel_count),
    .fb_wr_x(fb_wr_x),
    .fb_wr_y(fb_wr_y),
    .fb_wr_index(fb_wr_index),
    .fb_wr_en(fb_wr_en),
    .fb_wr_ready(fb_wr_ready)
  );

  always #5 clk = ~clk;

  // Framebuffer ready: either driven by the directed tests or randomized
  assign fb_wr_ready = rand_ready ? rnd_bit : ready_manual;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(3) != 0);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference pixel list of a command, straight from the fill rules
  function automatic void buildPixels(input int x0, input int y0, input int w, input int h,
                                      input int mode, input int fg, input int bg,
                                      input logic [PB-1:0] pat);
    int we;
    int he;
    bit p;
    pix_t e;
    build_q.delete();
    we = w;
    he = h;
`ifdef RECT_FILL_CLIP_EN
    if (x0 >= RX || y0 >= RY) begin
      we = 0;
      he = 0;
    end else begin
      if (x0 + w > RX) we = RX - x0;
      if (y0 + h > RY) he = RY - y0;
    end
`endif
    for (int j = 0; j < he; j++) begin
      for (int i = 0; i < we; i++) begin
        p     = pat[i % PB];
        e.x   = (x0 + i) % (1 << XW);
        e.y   = (y0 + j) % (1 << YW);
        e.en  = (mode == 1) ? p : 1'b1;
        e.idx = (mode == 2 && !p) ? bg : fg;
        build_q.push_back(e);
      end
    end
  endfunction

  // Cycle-by-cycle comparison of the DUT against the pixel-list model
  always @(negedge clk) begin
    mstate_t nst;
    pix_t    hd;
    if (!reset_n) begin
      mst  = M_IDLE;
      mcnt = 0;
      exp_q.delete();
    end else begin
      nst = mst;
      checkOutput("cmd_ready", int'(cmd_ready), int'(mst == M_IDLE));
      checkOutput("busy", int'(busy), int'(mst == M_DRAW));
      checkOutput("done", int'(done), int'(mst == M_DONE));
      checkOutput("pixel_count", int'(pixel_count), mcnt);
      case (mst)
        M_IDLE: begin
          checkOutput("wr_en_idle", int'(fb_wr_en), 0);
          if (cmd_valid) begin
            buildPixels(int'(cmd_x0), int'(cmd_y0), int'(cmd_w), int'(cmd_h),
                        int'(cmd_mode), int'(cmd_index), int'(cmd_bg_index), cmd_pattern);
            exp_q = build_q;
            mcnt  = 0;
            nst   = (exp_q.size() == 0) ? M_DONE : M_DRAW;
          end
        end
        M_DRAW: begin
          draw_cycles++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL model_queue actual=empty expected=pixel");
            nst = M_IDLE;
          end else begin
            hd = exp_q[0];
            checkOutput("fb_wr_en", int'(fb_wr_en), int'(hd.en));
            if (hd.en) begin
              checkOutput("fb_wr_x", int'(fb_wr_x), hd.x);
              checkOutput("fb_wr_y", int'(fb_wr_y), hd.y);
              checkOutput("fb_wr_index", int'(fb_wr_index), hd.idx);
            end
            if (hd.en && fb_wr_ready) begin
              mcnt++;
              wr_seen++;
            end
            if (abort) begin
              exp_q.delete();
              nst = M_IDLE;
            end else if (!hd.en || fb_wr_ready) begin
              void'(exp_q.pop_front());
              if (exp_q.size() == 0) nst = M_DONE;
            end
          end
        end
        M_DONE: begin
          checkOutput("wr_en_done", int'(fb_wr_en), 0);
          nst = M_IDLE;
        end
        default: nst = M_IDLE;
      endcase
      mst = nst;
    end
  end

  task automatic applyStimulus(input int x0, input int y0, input int w, input int h,
                               input int mode, input int fg, input int bg,
                               input logic [PB-1:0] pat);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    cmd_x0       = XW'(x0);
    cmd_y0       = YW'(y0);
    cmd_w        = (XW+1)'(w);
    cmd_h        = (YW+1)'(h);
    cmd_mode     = 2'(mode);
    cmd_index    = IW'(fg);
    cmd_bg_index = IW'(bg);
    cmd_pattern  = pat;
    cmd_valid    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=no_ready expected=cmd_ready");
    end
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    cmd_x0       = XW'($urandom);
    cmd_y0       = YW'($urandom);
    cmd_w        = (XW+1)'($urandom);
    cmd_h        = (YW+1)'($urandom);
    cmd_mode     = 2'($urandom);
    cmd_index    = IW'($urandom);
    cmd_bg_index = IW'($urandom);
    cmd_pattern  = $urandom;
  endtask

  task automatic waitIdle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (mst == M_IDLE) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  initial begin
    int w0;
    int d0;
    int rx0;
    reset_n      = 1'b0;
    cmd_valid    = 1'b0;
    abort        = 1'b0;
    cmd_x0       = '0;
    cmd_y0       = '0;
    cmd_w        = '0;
    cmd_h        = '0;
    cmd_mode     = '0;
    cmd_index    = '0;
    cmd_bg_index = '0;
    cmd_pattern  = '0;

    buildPixels(10, 20, 3, 2, 0, 'h5A, 0, 32'h0);
    checkOutput("model_solid_len", build_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      checkOutput("model_solid_x", build_q[k].x, sx[k]);
      checkOutput("model_solid_y", build_q[k].y, sy[k]);
      checkOutput("model_solid_idx", build_q[k].idx, 'h5A);
    end
    buildPixels(30, 40, 4, 1, 1, 'h22, 'h03, 32'h5);
    checkOutput("model_transp_en0", int'(build_q[0].en), 1);
    checkOutput("model_transp_en1", int'(build_q[1].en), 0);
    checkOutput("model_transp_en2", int'(build_q[2].en), 1);
    checkOutput("model_transp_en3", int'(build_q[3].en), 0);
    buildPixels(30, 40, 4, 1, 2, 'h22, 'h03, 32'h5);
    checkOutput("model_opaque_idx1", build_q[1].idx, 'h03);
    checkOutput("model_opaque_idx2", build_q[2].idx, 'h22);
    buildPixels(398, 0, 5, 1, 0, 1, 0, 32'h0);
`ifdef RECT_FILL_CLIP_EN
    checkOutput("model_clip_len", build_q.size(), 2);
`else
    checkOutput("model_wrap_len", build_q.size(), 5);
    checkOutput("model_wrap_x4", build_q[4].x, 402);
    buildPixels(510, 0, 4, 1, 0, 1, 0, 32'h0);
    checkOutput("model_wrap_x2", build_q[2].x, 0);
`endif

    #12;
    checkOutput("rst_cmd_ready", int'(cmd_ready), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_wr_en", int'(fb_wr_en), 0);
    checkOutput("rst_count", int'(pixel_count), 0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    // Solid fill
    w0 = wr_seen;
    applyStimulus(10, 20, 3, 2, 0, 'h5A, 0, 32'h0);
    waitIdle(100);
    checkOutput("solid_count", int'(pixel_count), 6);
    checkOutput("solid_writes", wr_seen - w0, 6);

    // Transparent fill: four DRAW cycles, two writes
    d0 = draw_cycles;
    applyStimulus(30, 40, 4, 1, 1, 'h22, 'h03, 32'h5);
    waitIdle(100);
    checkOutput("transp_count", int'(pixel_count), 2);
    checkOutput("transp_cycles", draw_cycles - d0, 4);

    // Opaque fill
    applyStimulus(30, 40, 4, 1, 2, 'h22, 'h03, 32'h5);
    waitIdle(100);
    checkOutput("opaque_count", int'(pixel_count), 4);

    // Backpressure on the second pixel for three cycles
    w0 = wr_seen;
    applyStimulus(10, 20, 4, 1, 0, 'h5A, 0, 32'h0);
    @(posedge clk);
    #1;
    ready_manual = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ready_manual = 1'b1;
    waitIdle(100);
    checkOutput("bp_count", int'(pixel_count), 4);
    checkOutput("bp_writes", wr_seen - w0, 4);

    // Zero-width command
    w0 = wr_seen;
    applyStimulus(5, 5, 0, 3, 0, 'h11, 0, 32'h0);
    waitIdle(20);
    checkOutput("w0_count", int'(pixel_count), 0);
    checkOutput("w0_writes", wr_seen - w0, 0);

    // Right-edge command: clipped or wrapped depending on the build
    applyStimulus(398, 10, 5, 1, 0, 'h33, 0, 32'h0);
    waitIdle(100);
`ifdef RECT_FILL_CLIP_EN
    checkOutput("edge_count", int'(pixel_count), 2);
`else
    checkOutput("edge_count", int'(pixel_count), 5);
`endif
    applyStimulus(400, 10, 3, 1, 0, 'h33, 0, 32'h0);
    waitIdle(100);
`ifdef RECT_FILL_CLIP_EN
    checkOutput("offscreen_count", int'(pixel_count), 0);
`else
    checkOutput("offscreen_count", int'(pixel_count), 3);
`endif

    // Abort after five writes of a hundred
    w0 = wr_seen;
    applyStimulus(0, 50, 100, 1, 0, 'h44, 0, 32'h0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (wr_seen - w0 >= 5) break;
    end
    ready_manual = 1'b0;
    abort        = 1'b1;
    @(posedge clk);
    #1;
    abort        = 1'b0;
    ready_manual = 1'b1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_count", int'(pixel_count), 5);
    waitIdle(10);
    repeat (3) @(posedge clk);
    checkOutput("abort_writes", wr_seen - w0, 5);

    // Reset in the middle of a fill
    rand_ready = 1'b1;
    applyStimulus(0, 0, 20, 3, 0, 'h77, 0, 32'h0);
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_cmd_ready", int'(cmd_ready), 1);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_done", int'(done), 0);
    checkOutput("mid_rst_wr_en", int'(fb_wr_en), 0);
    checkOutput("mid_rst_count", int'(pixel_count), 0);
    checkOutput("mid_rst_x", int'(fb_wr_x), 0);
    checkOutput("mid_rst_y", int'(fb_wr_y), 0);
    checkOutput("mid_rst_idx", int'(fb_wr_index), 0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Random commands with random backpressure, some near the wrap edge
    for (int n = 0; n < 40; n++) begin
      rx0 = (n % 5 == 0) ? 500 + int'($urandom_range(11)) : int'($urandom_range(511));
      applyStimulus(rx0, int'($urandom_range(511)), int'($urandom_range(7)),
                    int'($urandom_range(4)), int'($urandom_range(3)),
                    int'($urandom_range(255)), int'($urandom_range(255)), $urandom);
      waitIdle(400);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rect_fill_engine.md
RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 SHALL have parameter RESOLUTION_X, default 400, framebuffer width in pixels; XW = $clog2(RESOLUTION_X).
REQ-002 SHALL have parameter RESOLUTION_Y, default 300, framebuffer height in pixels; YW = $clog2(RESOLUTION_Y).
REQ-003 SHALL have parameter PALETTE_LENGTH, default 256, palette entries; IW = $clog2(PALETTE_LENGTH).
REQ-004 SHALL have parameter PATTERN_BITS, default 32, pattern length; a power of two, at least 2.
REQ-005 SHALL have ports: clk input 1 clock, all state on rising edge; reset_n input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_x0 in XW; cmd_y0 in YW; cmd_w in XW+1; cmd_h in YW+1 (command channel).
REQ-007 SHALL have ports: cmd_mode in 2; cmd_index in IW foreground; cmd_bg_index in IW background; cmd_pattern in PATTERN_BITS.
REQ-008 SHALL have ports: abort in 1; busy out 1; done out 1; pixel_count out $clog2(RESOLUTION_X*RESOLUTION_Y+1).
REQ-009 SHALL have ports: fb_wr_x out XW; fb_wr_y out YW; fb_wr_index out IW; fb_wr_en out 1; fb_wr_ready in 1 (framebuffer write channel).

Function
REQ-010 SHALL implement states IDLE, DRAW and DONE; cmd_ready = 1 only in IDLE; busy = 1 in DRAW.
REQ-011 SHALL accept a command on cmd_valid && cmd_ready, latch all cmd_* fields, clear pixel_count, and enter DRAW; if the effective w or h is 0, SHALL enter DONE instead.
REQ-012 SHALL traverse the rectangle in raster order: x from x0 to x0+w-1, then y+1. Coordinate (x0,y0) SHALL be presented in the first DRAW cycle.
REQ-013 SHALL set the pattern bit p = cmd_pattern[(x - x0) mod PATTERN_BITS] for each pixel.
REQ-014 SHALL apply cmd_mode per pixel:
- 00 solid: write cmd_index.
- 01 transparent: write cmd_index only when p=1.
- 10 opaque: write cmd_index when p=1, else cmd_bg_index.
- 11: behave as 00.
REQ-015 SHALL assert fb_wr_en for a written pixel and hold x, y and index stable until fb_wr_ready; the pixel completes in the cycle where fb_wr_en && fb_wr_ready.
REQ-016 SHALL drive fb_wr_en = 0 for a skipped pixel (mode 01, p=0); the pixel completes in one cycle regardless of fb_wr_ready.
REQ-017 SHALL increment pixel_count by 1 for each completed write; skipped pixels are not counted.
REQ-018 SHALL enter DONE after the last pixel completes; DONE lasts exactly one cycle with done = 1, then returns to IDLE.
REQ-019 SHALL make abort in DRAW return to IDLE next cycle with no done pulse and no further writes, and hold pixel_count.
REQ-020 SHALL ignore abort in IDLE and DONE.
REQ-021 SHALL keep fb_wr_en = 0 outside DRAW; fb_wr_x, fb_wr_y and fb_wr_index are don't-care while fb_wr_en = 0.
REQ-022 SHALL keep all cmd_* latches stable for the whole command; input changes after acceptance have no effect.

Reset
REQ-023 SHALL on reset_n = 0, immediately and asynchronously, go to IDLE and set: cmd_ready=1, busy=0, done=0, fb_wr_en=0, pixel_count=0, fb_wr_x=0, fb_wr_y=0, fb_wr_index=0.
REQ-024 SHALL on reset during DRAW abandon the command; no write is in flight after reset deasserts.

Configuration
REQ-025 SHALL use macro RECT_FILL_CLIP_EN; when defined, the latched rectangle is clipped at accept:
- x0 >= RESOLUTION_X or y0 >= RESOLUTION_Y: rectangle is empty.
- otherwise: x_end = min(x0+w, RESOLUTION_X) and y_end = min(y0+h, RESOLUTION_Y).
- pattern phase stays relative to the unclipped x0.
REQ-026 SHALL, when RECT_FILL_CLIP_EN is undefined, not clip; x and y are computed at full width and truncated to XW/YW bits (wrap modulo 2^XW / 2^YW).

Verification
REQ-027 SHALL cover solid fill: x0=10, y0=20, w=3, h=2, mode 00, index 0x5A, ready always 1 -> 6 writes (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), done 1 cycle, pixel_count=6.
REQ-028 SHALL cover transparent fill: w=4, h=1, pattern=...0101, mode 01 -> writes only at x0 and x0+2, pixel_count=2, 4 DRAW cycles. Opaque (mode 10, bg 0x03) -> 4 writes, alternating fg and 0x03.
REQ-029 SHALL cover backpressure: fb_wr_ready low for 3 cycles on the 2nd pixel -> x, y and index held, no duplicate or lost write, pixel_count identical to the ready-always-1 case.
REQ-030 SHALL cover abort and reset: abort after 5 of 100 writes -> IDLE next cycle, no done, pixel_count=5; reset_n low mid-DRAW -> all outputs at reset values asynchronously.
REQ-031 SHALL cover boundaries: w=0 -> done after 1 cycle, 0 writes.
- clip on, x0=398, w=5, h=1 -> writes at x=398 and 399 only.
- clip off, same command -> x wraps to 398,399,400,...,402 truncated to 9 bits.
- clip on, x0=400 -> 0 writes.
